// File: rtl/fetch_unit.sv
// Instruction fetch stage: registered PC, IF/ID register, halt/fault stop states.
// Optional halt-opcode detection is enabled by defining HALT_DETECT_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic [31:0] inst_in,
  output logic [31:0] pc_out,
  output logic        ifid_valid,
  output logic [31:0] ifid_inst,
  output logic [31:0] ifid_pc_plus4,
  output logic        halted,
  output logic        addr_fault
);

  typedef enum logic [1:0] {
    INIT,
    RUN,
    HALTED,
    FAULT
  } state_t;

  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] p4_q, p4_d;
  logic        valid_q, valid_d;

  logic [31:0] pc_plus4;
  logic        out_of_range;
  logic        is_halt;
  logic        in_run, frozen;
  logic        run_redir, run_fault, run_stall;
  logic        run_halt, run_fetch;
  logic        unused_bits;

  assign pc_plus4     = pc_q + 32'd4;
  assign out_of_range = {1'b0, pc_q} >= MEM_BYTES;
  assign unused_bits  = ^redirect_target[1:0];

`ifdef HALT_DETECT_EN
  assign is_halt = inst_in[31:26] == 6'b101101;
`else
  assign is_halt = 1'b0;
`endif

  assign in_run    = state_q == RUN;
  assign frozen    = (state_q == HALTED) || (state_q == FAULT);
  assign run_redir = in_run && redirect_valid;
  assign run_fault = in_run && !redirect_valid && out_of_range;
  assign run_stall = in_run && !redirect_valid
                  && !out_of_range && stall;
  assign run_halt  = in_run && !redirect_valid
                  && !out_of_range && !stall && is_halt;
  assign run_fetch = in_run && !redirect_valid
                  && !out_of_range && !stall && !is_halt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= INIT;
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0;
      p4_q    <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      p4_q    <= p4_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      state_q == INIT: state_d = RUN;
      run_fault:       state_d = FAULT;
      run_halt:        state_d = HALTED;
      default:         state_d = state_q;
    endcase
  end

  // Datapath next values; HALTED/FAULT drop valid after the last capture.
  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    p4_d    = p4_q;
    valid_d = valid_q;
    unique case (1'b1)
      run_redir: begin
        pc_d    = {redirect_target[31:2], 2'b00};
        inst_d  = 32'h0;
        valid_d = 1'b0;
      end
      run_fault: valid_d = 1'b0;
      run_stall: valid_d = valid_q;
      run_halt: begin
        inst_d  = inst_in;
        p4_d    = pc_plus4;
        valid_d = 1'b1;
      end
      run_fetch: begin
        inst_d  = inst_in;
        p4_d    = pc_plus4;
        valid_d = 1'b1;
        pc_d    = pc_plus4;
      end
      frozen:  valid_d = 1'b0;
      default: valid_d = valid_q;
    endcase
  end

  always_comb begin
    pc_out        = pc_q;
    ifid_valid    = valid_q;
    ifid_inst     = inst_q;
    ifid_pc_plus4 = p4_q;
    addr_fault    = state_q == FAULT;
`ifdef HALT_DETECT_EN
    halted        = state_q == HALTED;
`else
    halted        = 1'b0;
`endif
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter MEM_WORDS, default 64, instruction memory depth in 32-bit words.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port stall  input  1  hold PC and IF/ID register.
REQ-006 SHALL have port redirect_valid  input  1  branch/jump taken from a downstream stage.
REQ-007 SHALL have port redirect_target  input  32  new PC byte address.
REQ-008 SHALL have port inst_in  input  32  instruction word read combinationally from instruction memory at pc_out.
REQ-009 SHALL have port pc_out  output  32  byte address driven to instruction memory.
REQ-010 SHALL have port ifid_valid  output  1  IF/ID register holds a real instruction.
REQ-011 SHALL have port ifid_inst  output  32  IF/ID instruction.
REQ-012 SHALL have port ifid_pc_plus4  output  32  IF/ID PC+4 of that instruction.
REQ-013 SHALL have port halted  output  1  fetch stopped by halt instruction.
REQ-014 SHALL have port addr_fault  output  1  fetch stopped by out-of-range PC.

Function
REQ-015 SHALL implement FSM states INIT, RUN, HALTED, FAULT; pc_out is the registered PC.
REQ-016 SHALL stay in INIT exactly one cycle after reset deasserts (memory load cycle), PC unchanged, ifid_valid 0, then enter RUN.
REQ-017 SHALL, in RUN with stall=0 and redirect_valid=0, capture ifid_inst<=inst_in, ifid_pc_plus4<=PC+4, ifid_valid<=1, PC<=PC+4 (one-cycle fetch latency).
REQ-018 SHALL, in RUN with stall=1 and redirect_valid=0, hold PC, ifid_inst, ifid_pc_plus4, ifid_valid unchanged.
REQ-019 SHALL, on redirect_valid=1 in RUN (stall ignored), load PC<={redirect_target[31:2],2'b00}, and set ifid_valid<=0, ifid_inst<=32'h0 (bubble).
REQ-020 SHALL compute PC+4 modulo 2^32 (32'hFFFF_FFFC+4 wraps to 0).
REQ-021 SHALL, in RUN when PC >= MEM_WORDS*4 and no redirect, enter FAULT without capturing inst_in; addr_fault<=1, ifid_valid<=0.
REQ-022 SHALL, in HALTED or FAULT, freeze PC, hold ifid_valid at 0 after the final capture, and ignore stall and redirect_valid until reset.
REQ-023 SHALL give redirect priority over fault check (redirect to an out-of-range target faults one cycle later).

Reset
REQ-024 SHALL, when reset=0 on a rising edge, set PC<=RESET_PC, state<=INIT, ifid_valid<=0, ifid_inst<=0, ifid_pc_plus4<=0, halted<=0, addr_fault<=0.
REQ-025 SHALL give reset priority over every other input, including mid-stall, mid-redirect, HALTED and FAULT.

Configuration
REQ-026 SHALL, with HALT_DETECT_EN defined, treat inst_in[31:26]==6'b101101 captured in RUN (stall=0, no redirect) as halt: capture it into IF/ID with ifid_valid=1, keep PC, enter HALTED, halted<=1.
REQ-027 SHALL, without HALT_DETECT_EN, fetch opcode 6'b101101 as an ordinary instruction, never enter HALTED, and tie halted to 0.

Verification
REQ-028 SHALL cover: reset low 2 cycles, release, memory words 0..3 = A,B,C,D -> cycle1 INIT ifid_valid=0; cycles 2..5 ifid_inst=A,B,C,D, ifid_pc_plus4=4,8,12,16.
REQ-029 SHALL cover: stall high 3 cycles while ifid_inst=B, pc_out=8 -> pc_out stays 8, ifid_inst stays B, ifid_valid stays 1.
REQ-030 SHALL cover: redirect_valid=1, target=32'h0000_0023 with stall=1 -> next cycle pc_out=32'h20, ifid_valid=0, ifid_inst=0.
REQ-031 SHALL cover (HALT_DETECT_EN): word at 16 = 32'hB422_1820 -> captured with ifid_valid=1, halted=1, pc_out frozen at 16, later redirect ignored; without macro pc_out advances to 20.
REQ-032 SHALL cover: MEM_WORDS=64, sequential run reaching pc_out=256 -> addr_fault=1, ifid_valid=0, pc_out stays 256.
REQ-033 SHALL cover: reset=0 asserted while HALTED -> next cycle pc_out=RESET_PC, halted=0, state INIT.
